// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - Shared state encoding and sizing helpers for the chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // A single-chunk configuration still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - Combinational CHUNK-bit ripple adder with carry in/out.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - Multi-cycle add/sub, CHUNK bits per clock through a registered carry.
module chunked_seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_seq_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             c_chunk;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    a_chunk = a_r[int'(idx)*CHUNK +: CHUNK];
    b_chunk = b_r[int'(idx)*CHUNK +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_chunk),
    .b   (b_chunk),
    .cin (carry),
    .s   (s_chunk),
    .cout(c_chunk)
  );

  // Result including the chunk being computed this cycle, so the last RUN cycle can publish it directly.
  always_comb begin
    res_next = res;
    res_next[int'(idx)*CHUNK +: CHUNK] = s_chunk;
  end

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= A;
            b_r   <= Sub ? ~B : B;
            carry <= Sub;
            idx   <= '0;
            res   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= c_chunk;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            Sum       <= res_next;
            Cout      <= c_chunk;
            Ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_next[WIDTH-1] != a_r[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/chunked_seq_adder.md
Name: chunked_seq_adder

Overview:
Parametrised multi-cycle adder/subtractor. It is the successor to the team's 4-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, using a registered carry chain.
- Reports carry-out and signed overflow.
- Uses valid/ready handshakes on both input and output, so it can sit between pipelined datapath stages that tolerate multi-cycle latency in exchange for a short carry path.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
NCHUNK, WIDTH/CHUNK, derived localparam; number of RUN cycles per operation.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand set A/B/Sub is valid.
in_ready  output  1  block can accept an operation.
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
Sub  input  1  0 = A+B, 1 = A-B.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
Sum  output  WIDTH  result, modulo 2^WIDTH.
Cout  output  1  carry out of MSB; for Sub=1 it is the not-borrow flag (1 when A >= B unsigned).
Ovf  output  1  two's-complement signed overflow.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; out_valid=0, Sum=0, Cout=0, Ovf=0; internal registers (operands, carry, chunk index) cleared. in_ready=0 while rst=1.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a_r=A and b_r = Sub ? ~B : B, set carry=Sub, idx=0, go to RUN.
  - Inputs are sampled only at the accept edge; later changes on A/B/Sub are ignored.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: {c, s} = a_r[idx chunk] + b_r[idx chunk] + carry; write s into result chunk idx; carry <= c; idx <= idx+1.
  - When idx == NCHUNK-1:
    - Sum <= completed result (including the chunk computed this cycle).
    - Cout <= c.
    - Ovf <= (a_r[MSB] == b_r[MSB]) & (sum[MSB] != a_r[MSB]), where b_r is the already-inverted operand.
    - Go to DONE.
- DONE:
  - out_valid=1. Sum, Cout and Ovf are held stable. in_ready=0.
  - On out_ready=1: go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge. With CHUNK=WIDTH, latency is 1.
- Throughput: at best one operation per NCHUNK+2 cycles, because there is no overlap of accept and deliver.
- Sum/Cout/Ovf update only on entry to DONE and hold their last value in IDLE and RUN. Partial results are never visible.
- Carry ripples between chunks only through the carry register. No combinational path spans more than CHUNK bits plus the carry.
- Backpressure: out_ready low in DONE holds all outputs indefinitely. in_valid during DONE/RUN is ignored, and no operation is queued.
- Reset mid-operation (RUN or DONE): the operation is aborted and all outputs return to reset values on the next edge. No result is ever emitted for an aborted operation.
- Simultaneous in_valid and rst: reset wins; the operation is not accepted.
- Wrap-around: the result is truncated modulo 2^WIDTH, and the overflow information is carried in Cout/Ovf.
- WIDTH % CHUNK != 0 is illegal and must be caught by an elaboration-time check.

Decomposition:
- Shared package adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing the NCHUNK index width, as clog2 with a minimum of 1.
- One sub-module, chunk_adder: parametrised by CHUNK; inputs a, b, cin; outputs s, cout. It is purely combinational ripple logic, instantiated once and reused every RUN cycle.
- The FSM, index counter, operand registers and flag logic stay in chunked_seq_adder.

Test Plan:
1. WIDTH=16, CHUNK=4, after reset: A=0x0005, B=0x0005, Sub=0 -> out_valid exactly 4 cycles after accept; Sum=0x000A, Cout=0, Ovf=0.
2. A=0xFFFF, B=0x0001, Sub=0 -> Sum=0x0000, Cout=1, Ovf=0 (carry crosses all chunks). Then A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Ovf=1.
3. Subtraction cases:
   - A=0x0008, B=0x0002, Sub=1 -> Sum=0x0006, Cout=1, Ovf=0.
   - A=0x0002, B=0x0008 -> Sum=0xFFFA, Cout=0.
   - A=0x8000, B=0x0001 -> Sum=0x7FFF, Ovf=1.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> Sum/Cout/Ovf stable and in_ready=0 throughout. After out_ready=1: out_valid drops the next cycle, then the new operation is accepted and gives the correct result.
5. Assert rst during RUN at idx=2 -> next edge: out_valid=0, Sum=0, state IDLE. After rst deasserts, in_ready=1 and 0x1234+0x4321 gives Sum=0x5555.
6. Re-elaborate with CHUNK=16 and with CHUNK=1, running cases 1-3 -> identical results, with latency 1 and 16 cycles respectively.
